// File: rtl/lfsr_prng_core_if.sv
// Sample stream between the PRNG core and its consumer: rnd_valid/rnd_ready
// handshake carrying one OUT_W-bit rnd_data word per transfer.
interface lfsr_prng_core_if #(
  parameter int OUT_W = 8
);
  logic             rnd_valid;
  logic             rnd_ready;
  logic [OUT_W-1:0] rnd_data;

  modport master (output rnd_valid, output rnd_data, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/lfsr_prng_core.sv
// Two XNOR Fibonacci LFSRs: a slow data LFSR and a fast select LFSR whose bits
// pick between bit pairs of the data LFSR. Define PRNG_SEG7_EN for hex 7-seg outputs.
module lfsr_prng_core #(
  parameter int               OUT_W     = 8,
  parameter logic [2*OUT_W-1:0] DATA_TAPS = 16'hD008,
  parameter logic [OUT_W-1:0] SEL_TAPS  = 8'hB8,
  parameter logic [23:0]      DIV_MAX   = 24'd10_000_000
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [2*OUT_W-1:0]   seed,
  lfsr_prng_core_if.master     rnd,
  output logic                 lock_err,
  output logic                 ovf
`ifdef PRNG_SEG7_EN
  ,
  output logic [6:0]           seg_lo,
  output logic [6:0]           seg_hi
`endif
);

  localparam int DW = 2 * OUT_W;
  localparam logic [DW-1:0] ALL_ONES = '1;

  if (OUT_W < 4 || OUT_W > 16) begin : g_bad_out_w
    $error("lfsr_prng_core: OUT_W must be within 4..16");
  end
  if (DIV_MAX == 24'd0) begin : g_bad_div_max
    $error("lfsr_prng_core: DIV_MAX must be at least 1");
  end

  logic [DW-1:0]    data_q;
  logic [DW-1:0]    data_step;
  logic [OUT_W-1:0] sel_q;
  logic [OUT_W-1:0] sel_step;
  logic [OUT_W-1:0] mix;
  logic [OUT_W-1:0] out_q;
  logic [23:0]      div_q;
  logic             valid_q;
  logic             tick;

  assign tick = en && (div_q == DIV_MAX - 24'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data_step = {data_q[DW-2:0], ~^(data_q & DATA_TAPS)};
    sel_step  = {sel_q[OUT_W-2:0], ~^(sel_q & SEL_TAPS)};
    mix       = '0;
    for (int j = 0; j < OUT_W; j++) begin
      mix[j] = sel_q[j] ? data_q[2*j+1] : data_q[2*j];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      sel_q    <= '0;
      div_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      lock_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (seed_load) begin
        // All-ones is the XNOR lock state; substitute zero so the sequence keeps moving.
        if (seed == ALL_ONES) begin
          data_q   <= '0;
          lock_err <= 1'b1;
        end else begin
          data_q <= seed;
        end
        sel_q   <= seed[DW-1:OUT_W];
        div_q   <= '0;
        valid_q <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        if (en) begin
          sel_q <= sel_step;
          div_q <= tick ? 24'd0 : div_q + 24'd1;
        end
        if (tick) begin
          if (data_q == ALL_ONES) begin
            data_q   <= '0;
            lock_err <= 1'b1;
          end else begin
            data_q <= data_step;
          end
          if (!valid_q || rnd.rnd_ready) begin
            out_q   <= mix;
            valid_q <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end else if (valid_q && rnd.rnd_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign rnd.rnd_valid = valid_q;
  assign rnd.rnd_data  = out_q;

`ifdef PRNG_SEG7_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b0000000;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      4'hF: s = 7'b1110001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign seg_lo = hex7(out_q[3:0]);
  assign seg_hi = hex7(out_q[7:4]);
`endif

endmodule

// File: tb/tb_lfsr_prng_core.sv
// Directed bench for lfsr_prng_core: three instances (DIV_MAX 4, 1, 3) share
// clock, reset and control inputs; each scenario resets and exercises one instance.
module tb_lfsr_prng_core;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        lock_err4, ovf4, lock_err1, ovf1, lock_err3, ovf3;

  int checks = 0;
  int failures = 0;

  lfsr_prng_core_if #(.OUT_W(8)) bus4 ();
  lfsr_prng_core_if #(.OUT_W(8)) bus1 ();
  lfsr_prng_core_if #(.OUT_W(8)) bus3 ();

  lfsr_prng_core #(.OUT_W(8), .DIV_MAX(24'd4)) u4 (
    .CLK(CLK), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
    .rnd(bus4), .lock_err(lock_err4), .ovf(ovf4)
  );
  lfsr_prng_core #(.OUT_W(8), .DIV_MAX(24'd1)) u1 (
    .CLK(CLK), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
    .rnd(bus1), .lock_err(lock_err1), .ovf(ovf1)
  );
  lfsr_prng_core #(.OUT_W(8), .DIV_MAX(24'd3)) u3 (
    .CLK(CLK), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
    .rnd(bus3), .lock_err(lock_err3), .ovf(ovf3)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Reset all instances; release 1 unit after an edge so the next edge is edge 1.
  task automatic do_reset();
    en = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    bus4.rnd_ready = 1'b0;
    bus1.rnd_ready = 1'b0;
    bus3.rnd_ready = 1'b0;
    rst = 1'b0;
    edges(2);
    rst = 1'b1;
  endtask

  // Valid pattern for DIV_MAX=3 with ready held high: sample on every third edge.
  logic [8:0] exp_pat;

  initial begin
    bus4.rnd_ready = 1'b0;
    bus1.rnd_ready = 1'b0;
    bus3.rnd_ready = 1'b0;

    // Reset state.
    #3;
    check("rst_valid", 32'(bus4.rnd_valid), 32'd0);
    check("rst_data", 32'(bus4.rnd_data), 32'h00);
    check("rst_lock", 32'(lock_err4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_lfsr", 32'(u4.data_q), 32'h0000);

    // DIV_MAX=4, ready low: first sample on edge 4, overflow on edge 8.
    do_reset();
    en = 1'b1;
    edges(3);
    check("d4_valid_e3", 32'(bus4.rnd_valid), 32'd0);
    edges(1);
    check("d4_valid_e4", 32'(bus4.rnd_valid), 32'd1);
    check("d4_data_e4", 32'(bus4.rnd_data), 32'h00);
    check("d4_lfsr_e4", 32'(u4.data_q), 32'h0001);
    edges(3);
    check("d4_ovf_e7", 32'(ovf4), 32'd0);
    edges(1);
    check("d4_ovf_e8", 32'(ovf4), 32'd1);
    check("d4_hold_e8", 32'(bus4.rnd_data), 32'h00);
    check("d4_valid_e8", 32'(bus4.rnd_valid), 32'd1);

    // DIV_MAX=3, ready held high.
    do_reset();
    en = 1'b1;
    bus3.rnd_ready = 1'b1;
    exp_pat = 9'b100100100;
    for (int i = 0; i < 9; i++) begin
      edges(1);
      check($sformatf("d3_valid_e%0d", i + 1), 32'(bus3.rnd_valid), 32'(exp_pat[i]));
    end
    check("d3_ovf", 32'(ovf3), 32'd0);

    // DIV_MAX=3: accept coincident with tick reloads without a bubble.
    do_reset();
    en = 1'b1;
    edges(3);
    check("nb_valid_e3", 32'(bus3.rnd_valid), 32'd1);
    edges(2);
    check("nb_hold_e5", 32'(bus3.rnd_valid), 32'd1);
    bus3.rnd_ready = 1'b1;
    edges(1);
    check("nb_valid_e6", 32'(bus3.rnd_valid), 32'd1);
    check("nb_data_e6", 32'(bus3.rnd_data), 32'h01);
    check("nb_ovf_e6", 32'(ovf3), 32'd0);
    edges(1);
    check("nb_valid_e7", 32'(bus3.rnd_valid), 32'd0);
    check("nb_data_e7", 32'(bus3.rnd_data), 32'h01);

    // Reset asserted mid-cycle with a sample pending clears outputs at once.
    bus3.rnd_ready = 1'b0;
    edges(2);
    check("ar_pre_valid", 32'(bus3.rnd_valid), 32'd1);
    rst = 1'b0;
    #2;
    check("ar_valid", 32'(bus3.rnd_valid), 32'd0);
    check("ar_data", 32'(bus3.rnd_data), 32'h00);
    check("ar_ovf", 32'(ovf3), 32'd0);
    check("ar_div", 32'(u3.div_q), 32'd0);
    // After release the first tick is DIV_MAX enabled edges away.
    edges(1);
    rst = 1'b1;
    en = 1'b1;
    edges(2);
    check("ar_post_e2", 32'(bus3.rnd_valid), 32'd0);
    edges(1);
    check("ar_post_e3", 32'(bus3.rnd_valid), 32'd1);

    // DIV_MAX=1 seed load with en low, then one tick.
    do_reset();
    seed = 16'hACE1;
    seed_load = 1'b1;
    edges(1);
    seed_load = 1'b0;
    check("sd_lfsr", 32'(u1.data_q), 32'hACE1);
    check("sd_sel", 32'(u1.sel_q), 32'hAC);
    check("sd_valid", 32'(bus1.rnd_valid), 32'd0);
    en = 1'b1;
    edges(1);
    check("sd_valid_t", 32'(bus1.rnd_valid), 32'd1);
    check("sd_data_t", 32'(bus1.rnd_data), 32'hAD);
    check("sd_lfsr_t", 32'(u1.data_q), 32'h59C2);
    edges(1);
    check("sd_ovf", 32'(ovf1), 32'd1);
    check("sd_hold", 32'(bus1.rnd_data), 32'hAD);
    // Seed load wins over a coincident tick and clears valid and ovf.
    seed_load = 1'b1;
    edges(1);
    seed_load = 1'b0;
    en = 1'b0;
    check("sp_valid", 32'(bus1.rnd_valid), 32'd0);
    check("sp_ovf", 32'(ovf1), 32'd0);
    check("sp_data", 32'(bus1.rnd_data), 32'hAD);

    // All-ones seed is replaced by zero with a single-cycle lock_err.
    seed = 16'hFFFF;
    seed_load = 1'b1;
    edges(1);
    seed_load = 1'b0;
    check("lk_lfsr", 32'(u1.data_q), 32'h0000);
    check("lk_pulse", 32'(lock_err1), 32'd1);
    edges(1);
    check("lk_clear", 32'(lock_err1), 32'd0);

    // en low mid-count freezes divider and LFSRs; handshake still consumes.
    do_reset();
    en = 1'b1;
    edges(2);
    en = 1'b0;
    edges(10);
    check("fz_div", 32'(u4.div_q), 32'd2);
    check("fz_sel", 32'(u4.sel_q), 32'h03);
    check("fz_lfsr", 32'(u4.data_q), 32'h0000);
    check("fz_valid", 32'(bus4.rnd_valid), 32'd0);
    en = 1'b1;
    edges(1);
    check("fz_res_div", 32'(u4.div_q), 32'd3);
    check("fz_res_v1", 32'(bus4.rnd_valid), 32'd0);
    edges(1);
    check("fz_res_v2", 32'(bus4.rnd_valid), 32'd1);
    en = 1'b0;
    bus4.rnd_ready = 1'b1;
    edges(1);
    check("fz_accept", 32'(bus4.rnd_valid), 32'd0);
    check("fz_div_hold", 32'(u4.div_q), 32'd0);
    check("fz_lfsr_hold", 32'(u4.data_q), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
